// File: rtl/gfx_sched_pkg.sv
// Shared types for the render scheduler: queued command format, payload layouts
// and scheduler FSM states.
package gfx_sched_pkg;

   localparam int TRI_W = 307;
   localparam int CLR_W = 52;

   // Bit positions inside mode_flags = {z_write, z_test, textured, gouraud}
   localparam int MODE_GOURAUD  = 0;
   localparam int MODE_TEXTURED = 1;
   localparam int MODE_Z_TEST   = 2;
   localparam int MODE_Z_WRITE  = 3;

   typedef enum logic {
      CMD_TRI = 1'b0,
      CMD_CLR = 1'b1
   } cmd_kind_e;

   typedef struct packed {
      logic [19:0]       fb_draw;
      logic [3:0]        mode_flags;
      logic [15:0]       inv_area;
      logic [2:0][31:0]  color;
      logic [2:0][24:0]  z;
      logic [2:0][15:0]  y;
      logic [2:0][15:0]  x;
   } tri_payload_t;

   typedef struct packed {
      logic [19:0] fb;
      logic [31:0] color;
   } clr_payload_t;

   typedef struct packed {
      logic [TRI_W-CLR_W-1:0] pad;
      clr_payload_t           clr;
   } clr_padded_t;

   typedef union packed {
      tri_payload_t tri_p;
      clr_padded_t  clr_p;
   } cmd_payload_u;

   typedef struct packed {
      cmd_kind_e    kind;
      cmd_payload_u payload;
   } sched_cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DISPATCH_TRI,
      ST_WAIT_RAST,
      ST_START_CLR,
      ST_WAIT_CLR
   } sched_state_e;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Command FIFO with two push ports (lower port fills first) and one pop port.
// A pop on the same edge frees a slot for the pushes.
module sched_cmd_fifo
   import gfx_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_lo,
   input  sched_cmd_t       data_lo,
   input  logic             push_hi,
   input  sched_cmd_t       data_hi,
   input  logic             pop,
   output sched_cmd_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);

   sched_cmd_t       mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W:0]   free_slots;
   logic             pop_ok;
   logic             acc_lo;
   logic             acc_hi;

   always_comb begin
      pop_ok     = pop && (count != '0);
      free_slots = (CNT_W+1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, pop_ok};
      acc_lo     = push_lo && (free_slots != '0);
      acc_hi     = push_hi && (free_slots > {{CNT_W{1'b0}}, acc_lo});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(acc_lo) + AW'(acc_hi);
         rd_ptr <= rd_ptr + AW'(pop_ok);
         count  <= count + CNT_W'(acc_lo) + CNT_W'(acc_hi) - CNT_W'(pop_ok);
      end
   end

   // Storage is not reset; only entries between the pointers are meaningful
   always_ff @(posedge clk) begin
      if (acc_lo)
         mem[wr_ptr] <= data_lo;
      if (acc_hi)
         mem[wr_ptr + AW'(acc_lo)] <= data_hi;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign drop  = (push_lo && !acc_lo) || (push_hi && !acc_hi);

endmodule

// File: rtl/render_scheduler.sv
// Queues triangle and clear events with their render state and dispatches them
// one at a time, in order, to the rasterizer or the clear engine.
module render_scheduler
   import gfx_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tri_valid,
   input  logic [2:0][15:0]       tri_x,
   input  logic [2:0][15:0]       tri_y,
   input  logic [2:0][24:0]       tri_z,
   input  logic [2:0][31:0]       tri_color,
   input  logic [15:0]            tri_inv_area,
   input  logic [3:0]             mode_flags,
   input  logic [19:0]            fb_draw,
   input  logic                   clear_trigger,
   input  logic [31:0]            clear_color,
   output logic                   rast_valid,
   input  logic                   rast_ready,
   input  logic                   rast_done,
   output logic [TRI_W-1:0]       rast_tri,
   output logic                   clear_start,
   output logic [19:0]            clear_fb,
   output logic [31:0]            clear_val,
   input  logic                   clear_done,
   output logic                   gpu_busy,
   output logic [CNT_W-1:0]       queue_count,
   output logic                   overflow,
   input  logic                   overflow_clr
);

   sched_cmd_t   tri_cmd;
   sched_cmd_t   clr_cmd;
   sched_cmd_t   head;
   logic         fifo_full;
   logic         fifo_empty;
   logic         fifo_drop;
   logic         pop;
   sched_state_e state_q;
   sched_state_e state_d;

   // The render state is captured alongside each event so later register
   // writes cannot leak into commands that are still queued
   always_comb begin
      tri_cmd                          = '0;
      tri_cmd.kind                     = CMD_TRI;
      tri_cmd.payload.tri_p.fb_draw    = fb_draw;
      tri_cmd.payload.tri_p.mode_flags = mode_flags;
      tri_cmd.payload.tri_p.inv_area   = tri_inv_area;
      tri_cmd.payload.tri_p.color      = tri_color;
      tri_cmd.payload.tri_p.z          = tri_z;
      tri_cmd.payload.tri_p.y          = tri_y;
      tri_cmd.payload.tri_p.x          = tri_x;
      clr_cmd                          = '0;
      clr_cmd.kind                     = CMD_CLR;
      clr_cmd.payload.clr_p.clr.fb     = fb_draw;
      clr_cmd.payload.clr_p.clr.color  = clear_color;
   end

   sched_cmd_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_lo (tri_valid),
      .data_lo (tri_cmd),
      .push_hi (clear_trigger),
      .data_hi (clr_cmd),
      .pop     (pop),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (queue_count),
      .drop    (fifo_drop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Only IDLE pops, so a new command never starts while an engine is working
   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      rast_valid  = 1'b0;
      clear_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = (head.kind == CMD_TRI) ? ST_DISPATCH_TRI : ST_START_CLR;
            end
         end
         ST_DISPATCH_TRI: begin
            rast_valid = 1'b1;
            if (rast_ready)
               state_d = ST_WAIT_RAST;
         end
         ST_WAIT_RAST: begin
            if (rast_done)
               state_d = ST_IDLE;
         end
         ST_START_CLR: begin
            clear_start = 1'b1;
            state_d     = ST_WAIT_CLR;
         end
         ST_WAIT_CLR: begin
            if (clear_done)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rast_tri  <= '0;
         clear_fb  <= '0;
         clear_val <= '0;
      end else if (pop) begin
         if (head.kind == CMD_TRI) begin
            rast_tri <= head.payload.tri_p;
         end else begin
            clear_fb  <= head.payload.clr_p.clr.fb;
            clear_val <= head.payload.clr_p.clr.color;
         end
      end
   end

   // A drop on the same edge as a clear request keeps the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overflow <= 1'b0;
      else if (fifo_drop)
         overflow <= 1'b1;
      else if (overflow_clr)
         overflow <= 1'b0;
   end

   assign gpu_busy = (state_q != ST_IDLE) || (queue_count != '0);

   fifo_full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full == (queue_count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: fill/overflow vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_render_scheduler;

   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             tri_valid = 1'b0;
   logic [2:0][15:0] tri_x = '0;
   logic [2:0][15:0] tri_y = '0;
   logic [2:0][24:0] tri_z = '0;
   logic [2:0][31:0] tri_color = '0;
   logic [15:0]      tri_inv_area = '0;
   logic [3:0]       mode_flags = '0;
   logic [19:0]      fb_draw = '0;
   logic             clear_trigger = 1'b0;
   logic [31:0]      clear_color = '0;
   logic             rast_valid;
   logic             rast_ready = 1'b0;
   logic             rast_done = 1'b0;
   logic [306:0]     rast_tri;
   logic             clear_start;
   logic [19:0]      clear_fb;
   logic [31:0]      clear_val;
   logic             clear_done = 1'b0;
   logic             gpu_busy;
   logic [CNT_W-1:0] queue_count;
   logic             overflow;
   logic             overflow_clr = 1'b0;

   always #5 clk = ~clk;

   render_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tri_valid    (tri_valid),
      .tri_x        (tri_x),
      .tri_y        (tri_y),
      .tri_z        (tri_z),
      .tri_color    (tri_color),
      .tri_inv_area (tri_inv_area),
      .mode_flags   (mode_flags),
      .fb_draw      (fb_draw),
      .clear_trigger(clear_trigger),
      .clear_color  (clear_color),
      .rast_valid   (rast_valid),
      .rast_ready   (rast_ready),
      .rast_done    (rast_done),
      .rast_tri     (rast_tri),
      .clear_start  (clear_start),
      .clear_fb     (clear_fb),
      .clear_val    (clear_val),
      .clear_done   (clear_done),
      .gpu_busy     (gpu_busy),
      .queue_count  (queue_count),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   typedef struct {
      bit           is_clr;
      logic [306:0] tri_v;
      logic [19:0]  cfb;
      logic [31:0]  cval;
   } cmd_t;

   typedef struct {
      bit          p_tri;
      bit          p_clr;
      bit          rdy;
      bit          oclr;
      logic [15:0] x0;
      logic [19:0] fb;
      logic [31:0] ccol;
      int          exp_count;
      bit          exp_ovf;
   } vec_t;

   // Reference model: pending commands plus the engine phase of the one in flight
   cmd_t         mq[$];
   int           m_cnt;
   bit           in_engine, accepted, rv_flag, clr_pend, cur_clr, m_ovf;
   int           timer;
   logic [306:0] exp_tri;
   logic [19:0]  exp_cfb;
   logic [31:0]  exp_cval;
   int           max_delay = 0;
   bit           hold_done = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [306:0] tri_vec();
      return {fb_draw, mode_flags, tri_inv_area, tri_color, tri_z, tri_y, tri_x};
   endfunction

   task automatic model_reset();
      mq.delete();
      m_cnt = 0; in_engine = 0; accepted = 0; rv_flag = 0; clr_pend = 0;
      cur_clr = 0; m_ovf = 0; timer = 0;
      exp_tri = '0; exp_cfb = '0; exp_cval = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tri_valid = 0; clear_trigger = 0; rast_ready = 0; rast_done = 0;
      clear_done = 0; overflow_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rast_valid"}, 320'(rast_valid), 320'(0));
      check({tag, "_clear_start"}, 320'(clear_start), 320'(0));
      check({tag, "_gpu_busy"}, 320'(gpu_busy), 320'(0));
      check({tag, "_queue_count"}, 320'(queue_count), 320'(0));
      check({tag, "_overflow"}, 320'(overflow), 320'(0));
      check({tag, "_rast_tri"}, 320'(rast_tri), 320'(0));
      check({tag, "_clear_fb"}, 320'(clear_fb), 320'(0));
      check({tag, "_clear_val"}, 320'(clear_val), 320'(0));
   endtask

   task automatic randomize_payload();
      for (int i = 0; i < 3; i++) begin
         tri_x[i]     = 16'($urandom);
         tri_y[i]     = 16'($urandom);
         tri_z[i]     = 25'($urandom);
         tri_color[i] = $urandom;
      end
      tri_inv_area = 16'($urandom);
      mode_flags   = 4'($urandom);
      fb_draw      = 20'($urandom);
      clear_color  = $urandom;
   endtask

   // One clock: drive requests and engine responses, advance the model, compare
   task automatic apply_stimulus(input bit p_tri, input bit p_clr, input bit rdy,
                                 input bit oclr, input bit stray);
      bit   done_now, pop, tri_acc, clr_adv, acc_t, acc_c;
      int   free;
      cmd_t c, ct, cc;
      done_now = accepted && (timer == 0) && !hold_done;
      pop      = !in_engine && (m_cnt > 0);
      tri_acc  = rv_flag && rdy;
      clr_adv  = clr_pend;
      free     = DEPTH - m_cnt + int'(pop);
      acc_t    = p_tri && (free > 0);
      acc_c    = p_clr && (free > int'(acc_t));
      ct = '{0, tri_vec(), '0, '0};
      cc = '{1, '0, fb_draw, clear_color};
      tri_valid = p_tri; clear_trigger = p_clr; rast_ready = rdy; overflow_clr = oclr;
      rast_done  = (done_now && !cur_clr) || stray;
      clear_done = (done_now && cur_clr) || stray;
      @(posedge clk);
      #1;
      tri_valid = 0; clear_trigger = 0; overflow_clr = 0; rast_done = 0; clear_done = 0;
      if (done_now) begin
         in_engine = 0; accepted = 0;
      end else if (accepted && timer > 0) begin
         timer--;
      end
      if (tri_acc) begin
         rv_flag = 0; accepted = 1; timer = int'($urandom_range(32'(max_delay), 0));
      end
      if (clr_adv) begin
         clr_pend = 0; accepted = 1; timer = int'($urandom_range(32'(max_delay), 0));
      end
      if (pop) begin
         c = mq.pop_front();
         in_engine = 1; cur_clr = c.is_clr;
         if (c.is_clr) begin
            clr_pend = 1; exp_cfb = c.cfb; exp_cval = c.cval;
         end else begin
            rv_flag = 1; exp_tri = c.tri_v;
         end
      end
      if (acc_t) mq.push_back(ct);
      if (acc_c) mq.push_back(cc);
      m_cnt = m_cnt + int'(acc_t) + int'(acc_c) - int'(pop);
      if ((p_tri && !acc_t) || (p_clr && !acc_c)) m_ovf = 1;
      else if (oclr) m_ovf = 0;
      check_output();
   endtask

   task automatic check_output();
      check("rast_valid", 320'(rast_valid), 320'(rv_flag));
      check("clear_start", 320'(clear_start), 320'(clr_pend));
      check("rast_tri", 320'(rast_tri), 320'(exp_tri));
      check("clear_fb", 320'(clear_fb), 320'(exp_cfb));
      check("clear_val", 320'(clear_val), 320'(exp_cval));
      check("queue_count", 320'(queue_count), 320'(m_cnt));
      check("gpu_busy", 320'(gpu_busy), 320'((m_cnt != 0) || in_engine));
      check("overflow", 320'(overflow), 320'(m_ovf));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && (m_cnt != 0 || in_engine); i++)
         apply_stimulus(0, 0, 1, 0, 0);
      check({tag, "_drained"}, 320'(gpu_busy), 320'(0));
   endtask

   initial begin
      vec_t  tbl[9];
      string seq;
      bit    prev_rv;

      tbl[0] = '{1, 0, 0, 0, 16'h0100, 20'h00010, 32'h0000_0000, 1, 0};
      tbl[1] = '{0, 0, 0, 0, 16'h0000, 20'h00000, 32'h0000_0000, 0, 0};
      tbl[2] = '{1, 0, 0, 0, 16'h0222, 20'h00020, 32'h0000_0000, 1, 0};
      tbl[3] = '{0, 1, 0, 0, 16'h0000, 20'h00030, 32'h1234_5678, 2, 0};
      tbl[4] = '{1, 1, 0, 0, 16'h0444, 20'h00040, 32'h8765_4321, 4, 0};
      tbl[5] = '{1, 0, 0, 0, 16'h0555, 20'h00050, 32'h0000_0000, 4, 1};
      tbl[6] = '{0, 0, 0, 1, 16'h0000, 20'h00000, 32'h0000_0000, 4, 0};
      tbl[7] = '{1, 0, 0, 1, 16'h0777, 20'h00070, 32'h0000_0000, 4, 1};
      tbl[8] = '{0, 0, 0, 0, 16'h0000, 20'h00000, 32'h0000_0000, 4, 1};

      #2;
      check_zero("in_reset");
      do_reset();
      check_zero("after_reset");

      // Fill to DEPTH with the rasterizer stalled, then overflow and its clear
      for (int i = 0; i < 9; i++) begin
         tri_x[0] = tbl[i].x0; fb_draw = tbl[i].fb; clear_color = tbl[i].ccol;
         apply_stimulus(tbl[i].p_tri, tbl[i].p_clr, tbl[i].rdy, tbl[i].oclr, 0);
         check("tbl_count", 320'(queue_count), 320'(tbl[i].exp_count));
         check("tbl_overflow", 320'(overflow), 320'(tbl[i].exp_ovf));
      end
      check("tbl_held_x", 320'(rast_tri[15:0]), 320'(16'h0100));

      // Push on the popping edge with the queue full, then drop vs clear
      apply_stimulus(0, 0, 1, 1, 0);
      apply_stimulus(0, 0, 1, 0, 0);
      apply_stimulus(1, 0, 1, 0, 0);
      check("full_pushpop_count", 320'(queue_count), 320'(4));
      check("full_pushpop_ovf", 320'(overflow), 320'(0));
      apply_stimulus(1, 0, 1, 1, 0);
      check("drop_beats_clr", 320'(overflow), 320'(1));
      drain("full");

      // Single triangle latency and busy timing
      do_reset();
      tri_x[0] = 16'h0100; tri_x[1] = 16'h0200; tri_x[2] = 16'h0300;
      apply_stimulus(1, 0, 1, 0, 0);
      check("single_busy_after_push", 320'(gpu_busy), 320'(1));
      check("single_no_early_valid", 320'(rast_valid), 320'(0));
      apply_stimulus(0, 0, 1, 0, 0);
      check("single_valid", 320'(rast_valid), 320'(1));
      check("single_x", 320'(rast_tri[47:0]), 320'(48'h0300_0200_0100));
      apply_stimulus(0, 0, 1, 0, 0);
      apply_stimulus(0, 0, 1, 0, 0);
      check("single_idle_after_done", 320'(gpu_busy), 320'(0));

      // Snapshot of fb_draw plus a 10-cycle rasterizer stall
      do_reset();
      fb_draw = 20'h00010;
      apply_stimulus(1, 0, 0, 0, 0);
      fb_draw = 20'h00080;
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(0, 0, 0, 0, 0);
         check("stall_valid", 320'(rast_valid), 320'(1));
         check("snapshot_fb", 320'(rast_tri[306:287]), 320'(20'h00010));
      end
      drain("stall");

      // Ordering: TRI, CLR, TRI with slow engines
      do_reset();
      max_delay = 2;
      seq = "";
      prev_rv = 0;
      tri_x[0] = 16'hAAAA;
      apply_stimulus(1, 0, 1, 0, 0);
      clear_color = 32'hFF00FF00;
      apply_stimulus(0, 1, 1, 0, 0);
      if (rast_valid) begin seq = {seq, "T"}; prev_rv = 1; end
      tri_x[0] = 16'hBBBB;
      apply_stimulus(1, 0, 1, 0, 0);
      for (int i = 0; i < 60 && (m_cnt != 0 || in_engine); i++) begin
         if (rast_valid && !prev_rv) seq = {seq, "T"};
         if (clear_start) begin
            seq = {seq, "C"};
            check("order_clear_val", 320'(clear_val), 320'(32'hFF00FF00));
         end
         prev_rv = rast_valid;
         apply_stimulus(0, 0, 1, 0, 0);
      end
      check("order_sequence", 320'(seq == "TCT"), 320'(1));
      check("order_last_x", 320'(rast_tri[15:0]), 320'(16'hBBBB));

      // Reset in WAIT_RAST with three queued, then a stray done
      do_reset();
      max_delay = 0;
      hold_done = 1;
      apply_stimulus(1, 0, 1, 0, 0);
      apply_stimulus(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) apply_stimulus(1, 0, 1, 0, 0);
      check("mid_count_before_reset", 320'(queue_count), 320'(3));
      rst_n = 1'b0;
      #2;
      check_zero("mid_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      hold_done = 0;
      apply_stimulus(0, 0, 1, 0, 1);
      apply_stimulus(0, 0, 1, 0, 0);
      check("stray_no_dispatch", 320'(rast_valid), 320'(0));

      // Randomized traffic against the model
      do_reset();
      max_delay = 3;
      for (int i = 0; i < 1500; i++) begin
         randomize_payload();
         apply_stimulus(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 3) != 0,
                        ($urandom % 16) == 0, !in_engine && (($urandom % 8) == 0));
      end
      drain("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
